// File: rtl/aww_types_pkg.sv
// aww_types_pkg: shared pipeline types, hazard FSM state and the load-use detect helper.
package aww_types_pkg;
    localparam int REGW_C = 5;
    localparam int CNTW_C = 32;
    typedef enum logic [1:0] {RUN, FLUSH, HALTED} hazard_state_t;
    function automatic logic is_load_use(
        input logic              memread,
        input logic [REGW_C-1:0] wsel,
        input logic [REGW_C-1:0] rs,
        input logic [REGW_C-1:0] rt
    );
        return memread && (wsel != '0) && ((wsel == rs) || (wsel == rt));
    endfunction
endpackage

// File: rtl/hazard_perf.sv
// hazard_perf: saturating event counters for hazard_ctrl, used only when HAZARD_PERF_EN is defined.
module hazard_perf #(
    parameter int CNTW = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            in_run,
    input  logic            ev_dstall,
    input  logic            ev_lu,
    input  logic            ev_redir,
    output logic [CNTW-1:0] cyc_cnt,
    output logic [CNTW-1:0] dstall_cnt,
    output logic [CNTW-1:0] lu_cnt,
    output logic [CNTW-1:0] redir_cnt
);
    // Every event is qualified by in_run, so the bank freezes in FLUSH/HALTED.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cyc_cnt    <= '0;
            dstall_cnt <= '0;
            lu_cnt     <= '0;
            redir_cnt  <= '0;
        end else begin
            if (in_run && cyc_cnt != '1) cyc_cnt <= cyc_cnt + 1'b1;
            if (in_run && ev_dstall && dstall_cnt != '1) dstall_cnt <= dstall_cnt + 1'b1;
            if (in_run && ev_lu && lu_cnt != '1) lu_cnt <= lu_cnt + 1'b1;
            if (in_run && ev_redir && redir_cnt != '1) redir_cnt <= redir_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline register-bank enables, stall/flush resolution and halt/dcache-flush sequencing.
// Optional perf counters via `define HAZARD_PERF_EN.
module hazard_ctrl
    import aww_types_pkg::*;
#(
    parameter int REGW = REGW_C,
    parameter int CNTW = CNTW_C
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            mem_dREN,
    input  logic            mem_dWEN,
    input  logic            idex_memread,
    input  logic [REGW-1:0] idex_wsel,
    input  logic [REGW-1:0] ifid_rs,
    input  logic [REGW-1:0] ifid_rt,
    input  logic            id_redirect,
    input  logic            memwb_halt,
    input  logic            dflush_done,
    output logic            WEN,
    output logic            ifid_WEN,
    output logic            ifid_FLUSH,
    output logic            pc_WEN,
    output logic            idex_bubble,
    output logic            dflush_req,
    output logic            halt
`ifdef HAZARD_PERF_EN
   ,output logic [CNTW-1:0] cyc_cnt,
    output logic [CNTW-1:0] dstall_cnt,
    output logic [CNTW-1:0] lu_cnt,
    output logic [CNTW-1:0] redir_cnt
`endif
);
    hazard_state_t state;
    logic dstall, lu, in_run, adv, fwd;
    assign dstall = (mem_dREN || mem_dWEN) && !dhit;
    assign lu     = is_load_use(idex_memread, REGW_C'(idex_wsel), REGW_C'(ifid_rs), REGW_C'(ifid_rt));
    // Outputs are gated by nRST so everything reads 0 while reset is held.
    assign in_run = nRST && state == RUN;
    assign adv    = in_run && !dstall && !memwb_halt;
    assign fwd    = adv && !lu;
    always_comb begin
        WEN         = adv;
        idex_bubble = adv && lu;
        pc_WEN      = fwd && (id_redirect || ihit);
        ifid_WEN    = fwd && !id_redirect && ihit;
        ifid_FLUSH  = fwd && (id_redirect || !ihit);
        dflush_req  = nRST && state == FLUSH;
        halt        = nRST && state == HALTED;
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= RUN;
        else state <= (state == RUN && memwb_halt && !dstall) ? FLUSH :
                      (state == FLUSH && dflush_done) ? HALTED : state;
    end
`ifdef HAZARD_PERF_EN
    hazard_perf #(.CNTW(CNTW)) u_perf (
        .CLK        (CLK),
        .nRST       (nRST),
        .in_run     (in_run),
        .ev_dstall  (dstall),
        .ev_lu      (adv && lu),
        .ev_redir   (fwd && id_redirect),
        .cyc_cnt    (cyc_cnt),
        .dstall_cnt (dstall_cnt),
        .lu_cnt     (lu_cnt),
        .redir_cnt  (redir_cnt)
    );
`else
    logic unused_cntw;
    assign unused_cntw = ^CNTW;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl enables, stalls, redirects and halt sequencing.
module tb_hazard_ctrl;
    logic CLK = 0, nRST = 0;
    logic ihit = 1, dhit = 0, mem_dREN = 0, mem_dWEN = 0, idex_memread = 0;
    logic [4:0] idex_wsel = 0, ifid_rs = 0, ifid_rt = 0;
    logic id_redirect = 0, memwb_halt = 0, dflush_done = 0;
    logic WEN, ifid_WEN, ifid_FLUSH, pc_WEN, idex_bubble, dflush_req, halt;
`ifdef HAZARD_PERF_EN
    logic [31:0] cyc_cnt, dstall_cnt, lu_cnt, redir_cnt;
`endif
    int checks = 0, errors = 0;
    // Output vector order: {WEN, ifid_WEN, ifid_FLUSH, pc_WEN, idex_bubble, dflush_req, halt}
    localparam logic [6:0] NORM = 7'b1101000, FRZ = 7'b0000000, LU = 7'b1000100,
                           REDIR = 7'b1011000, NOI = 7'b1010000, FL = 7'b0000010, HLT = 7'b0000001;

    hazard_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .idex_memread(idex_memread), .idex_wsel(idex_wsel), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .id_redirect(id_redirect), .memwb_halt(memwb_halt), .dflush_done(dflush_done),
        .WEN(WEN), .ifid_WEN(ifid_WEN), .ifid_FLUSH(ifid_FLUSH), .pc_WEN(pc_WEN),
        .idex_bubble(idex_bubble), .dflush_req(dflush_req), .halt(halt)
`ifdef HAZARD_PERF_EN
       ,.cyc_cnt(cyc_cnt), .dstall_cnt(dstall_cnt), .lu_cnt(lu_cnt), .redir_cnt(redir_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        #2;
        obs = {WEN, ifid_WEN, ifid_FLUSH, pc_WEN, idex_bubble, dflush_req, halt};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        #1 chk("reset_outputs_zero", FRZ);
        #9 nRST = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("run_normal", NORM);
            tick();
        end
        mem_dREN = 1; dhit = 0;
        for (int i = 0; i < 3; i++) begin
            chk("dstall_freeze", FRZ);
            tick();
        end
        dhit = 1;
        chk("dstall_release", NORM);
        tick();
        mem_dREN = 0; dhit = 0; mem_dWEN = 1; memwb_halt = 1;
        chk("dstall_over_halt", FRZ);
        tick();
        mem_dWEN = 0; memwb_halt = 0;
        chk("still_run_after_blocked_halt", NORM);
        tick();
        idex_memread = 1; idex_wsel = 8; ifid_rt = 8;
        chk("load_use_rt", LU);
        tick();
        idex_memread = 0;
        chk("load_use_one_cycle", NORM);
        tick();
        idex_memread = 1; idex_wsel = 0; ifid_rt = 0; ifid_rs = 0;
        chk("load_use_r0_ignored", NORM);
        tick();
        idex_wsel = 3; ifid_rs = 3; ifid_rt = 9; id_redirect = 1;
        chk("load_use_rs_over_redirect", LU);
        tick();
        idex_memread = 0;
        chk("redirect_ihit", REDIR);
        tick();
        ihit = 0;
        chk("redirect_no_ihit", REDIR);
        tick();
        id_redirect = 0;
        chk("ihit_miss", NOI);
        tick();
        ihit = 1; dflush_done = 1;
        chk("dflush_done_in_run", NORM);
        tick();
        dflush_done = 0;
        chk("run_after_stray_done", NORM);
        tick();
        memwb_halt = 1;
        chk("halt_enter_cycle", FRZ);
        tick();
        memwb_halt = 0;
        for (int i = 0; i < 5; i++) begin
            chk("flush_wait", FL);
            tick();
        end
        dflush_done = 1;
        chk("flush_done_cycle", FL);
        tick();
        chk("halted", HLT);
        tick();
        dflush_done = 0; memwb_halt = 1;
        chk("halted_terminal", HLT);
        tick();
        memwb_halt = 0;
        #2 nRST = 0;
        #1 nRST = 1;
        tick();
        chk("run_after_reset", NORM);
        tick();
        memwb_halt = 1;
        chk("halt_enter_again", FRZ);
        tick();
        memwb_halt = 0;
        chk("flush_again", FL);
        nRST = 0;
        chk("reset_mid_flush", FRZ);
        nRST = 1;
        chk("run_after_flush_reset", NORM);
        tick();
        chk("run_next_cycle", NORM);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
